// File: rtl/ysyx_22050854_mem_arbiter.sv
// Shares one memory port between IFU and LSU. LSU has priority, and a starvation counter bounds how long the IFU waits.
// Define ARB_PERF_CNT_EN to add 64-bit grant and stall performance counters.

module ysyx_22050854_mem_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_data,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic                lsu_req_wen,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data,
   output logic                busy
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [63:0]         perf_ifu_grant,
   output logic [63:0]         perf_lsu_grant,
   output logic [63:0]         perf_mem_stall
`endif
);

   localparam int MASK_W = DATA_W / 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [1:0]        state_q,  state_d;
   logic              owner_q,  owner_d;
   logic [3:0]        starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic              wen_q,    wen_d;
   logic [DATA_W-1:0] wdata_q,  wdata_d;
   logic [MASK_W-1:0] wmask_q,  wmask_d;

   logic grant_ifu;
   logic grant_lsu;
   logic resp_fire;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      starve_d  = starve_q;
      addr_d    = addr_q;
      wen_d     = wen_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      grant_ifu = 1'b0;
      grant_lsu = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The IFU is forced only after STARVE_MAX consecutive LSU wins over a waiting fetch.
            if (lsu_req_valid && !(ifu_req_valid && starve_q == STARVE_LIM)) begin
               grant_lsu = 1'b1;
            end else if (ifu_req_valid) begin
               grant_ifu = 1'b1;
            end

            if (grant_lsu) begin
               state_d  = ST_REQ;
               owner_d  = OWN_LSU;
               addr_d   = lsu_req_addr;
               wen_d    = lsu_req_wen;
               wdata_d  = lsu_req_wdata;
               wmask_d  = lsu_req_wmask;
               starve_d = ifu_req_valid ? starve_q + 4'd1 : 4'd0;
            end else if (grant_ifu) begin
               state_d  = ST_REQ;
               owner_d  = OWN_IFU;
               addr_d   = ifu_req_addr;
               wen_d    = 1'b0;
               wdata_d  = '0;
               wmask_d  = '0;
               starve_d = 4'd0;
            end else if (!ifu_req_valid) begin
               starve_d = 4'd0;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) state_d = ST_REQ + 2'd1;
         end
         ST_RESP: begin
            if (mem_resp_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= OWN_IFU;
         starve_q <= 4'd0;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
         wmask_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
      end
   end

   // A ready pulse never escapes while reset is held, even if a request is already pending.
   assign ifu_req_ready = grant_ifu & ~rst;
   assign lsu_req_ready = grant_lsu & ~rst;

   assign mem_req_valid = (state_q == ST_REQ);
   assign mem_req_addr  = addr_q;
   assign mem_req_wen   = wen_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;

   assign resp_fire      = (state_q == ST_RESP) && mem_resp_valid;
   assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
   assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
   assign ifu_resp_data  = ifu_resp_valid ? mem_resp_data : '0;
   assign lsu_resp_data  = lsu_resp_valid ? mem_resp_data : '0;

   assign busy = (state_q != ST_IDLE);

`ifdef ARB_PERF_CNT_EN
   logic [63:0] perf_ifu_q;
   logic [63:0] perf_lsu_q;
   logic [63:0] perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ifu_q   <= '0;
         perf_lsu_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (ifu_req_ready) perf_ifu_q <= perf_ifu_q + 64'd1;
         if (lsu_req_ready) perf_lsu_q <= perf_lsu_q + 64'd1;
         if ((state_q == ST_REQ && !mem_req_ready) || (state_q == ST_RESP && !mem_resp_valid)) begin
            perf_stall_q <= perf_stall_q + 64'd1;
         end
      end
   end

   assign perf_ifu_grant = perf_ifu_q;
   assign perf_lsu_grant = perf_lsu_q;
   assign perf_mem_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22050854_mem_arbiter.sv
// Randomized bench for ysyx_22050854_mem_arbiter. A transaction-level reference model and a reactive memory are checked against the DUT.
// A separate monitor scores response data against queues that are filled when each request is issued.

module tb_ysyx_22050854_mem_arbiter;

   localparam int ADDR_W     = 64;
   localparam int DATA_W     = 64;
   localparam int MASK_W     = 8;
   localparam int STARVE_MAX = 4;

   logic              clk;
   logic              rst;
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_req_addr;
   logic              ifu_resp_valid;
   logic [DATA_W-1:0] ifu_resp_data;
   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_req_addr;
   logic              lsu_req_wen;
   logic [DATA_W-1:0] lsu_req_wdata;
   logic [MASK_W-1:0] lsu_req_wmask;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_resp_data;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_wen;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [MASK_W-1:0] mem_req_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;
   logic              busy;
`ifdef ARB_PERF_CNT_EN
   logic [63:0]       perf_ifu_grant;
   logic [63:0]       perf_lsu_grant;
   logic [63:0]       perf_mem_stall;
`endif

   ysyx_22050854_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy)
`ifdef ARB_PERF_CNT_EN
      , .perf_ifu_grant(perf_ifu_grant), .perf_lsu_grant(perf_lsu_grant), .perf_mem_stall(perf_mem_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          st;
      logic [63:0] d;
   } lsu_exp_t;

   logic [63:0] ifu_q[$];
   lsu_exp_t    lsu_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Stimulus knobs
   bit rst_req    = 1'b1;
   bit stim_en    = 1'b0;
   bit force_resp = 1'b0;
   int p_ifu = 0, p_lsu = 0, p_rdy = 0;

   // Requester agents
   bit          ifu_pend = 1'b0;
   logic [63:0] ifu_addr = '0;
   bit          lsu_pend = 1'b0;
   logic [63:0] lsu_addr = '0, lsu_wdata = '0;
   logic        lsu_wen  = 1'b0;
   logic [7:0]  lsu_wmask = '0;

   // Reactive memory
   bit          mem_out   = 1'b0;
   int          mem_delay = 0;
   logic [63:0] mem_addr  = '0;
   logic        mem_wen   = 1'b0;

   // Transaction-level reference model: 0 free, 1 waiting for memory accept, 2 waiting for response
   int          phase  = 0;
   bit          m_lsu  = 1'b0;
   int          starve = 0;
   logic [63:0] x_addr = '0, x_wdata = '0;
   logic        x_wen  = 1'b0;
   logic [7:0]  x_wmask = '0;
   longint      m_ifu_g = 0, m_lsu_g = 0, m_stall = 0;

   function automatic logic [63:0] fdata(input logic [63:0] a);
      if (a == 64'h0000_0000_8000_0000) return 64'h0000_0000_0010_0073;
      return {~a[31:0], a[31:0] ^ 32'hC3A5_5A3C};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue_ifu(input logic [63:0] a, input bit track);
      ifu_pend = 1'b1;
      ifu_addr = a;
      if (track) ifu_q.push_back(fdata(a));
   endtask

   task automatic issue_lsu(input logic [63:0] a, input logic w, input logic [63:0] wd, input logic [7:0] wm);
      lsu_exp_t e;
      lsu_pend  = 1'b1;
      lsu_addr  = a;
      lsu_wen   = w;
      lsu_wdata = wd;
      lsu_wmask = wm;
      e.st = w;
      e.d  = fdata(a);
      lsu_q.push_back(e);
   endtask

   task automatic drive();
      rst = rst_req;
      if (stim_en && !ifu_pend && $urandom_range(0, 99) < p_ifu)
         issue_ifu(64'h8000_0000 + 64'($urandom_range(0, 255)) * 4, 1'b1);
      if (stim_en && !lsu_pend && $urandom_range(0, 99) < p_lsu)
         issue_lsu(64'h9000_0000 + 64'($urandom_range(0, 255)) * 8, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, 8'($urandom));
      ifu_req_valid = ifu_pend;
      ifu_req_addr  = ifu_addr;
      lsu_req_valid = lsu_pend;
      lsu_req_addr  = lsu_addr;
      lsu_req_wen   = lsu_wen;
      lsu_req_wdata = lsu_wdata;
      lsu_req_wmask = lsu_wmask;
      mem_req_ready  = ($urandom_range(0, 99) < p_rdy);
      mem_resp_valid = 1'b0;
      mem_resp_data  = {$urandom, $urandom};
      if (mem_out) begin
         if (mem_delay > 1) mem_delay--;
         else begin
            mem_resp_valid = 1'b1;
            if (!mem_wen) mem_resp_data = fdata(mem_addr);
         end
      end else if (force_resp || (!mem_req_ready && $urandom_range(0, 99) < 10)) begin
         mem_resp_valid = 1'b1;
      end
   endtask

   task automatic evaluate();
      bit e_ifu, e_lsu, e_resp;
      e_ifu = 1'b0;
      e_lsu = 1'b0;
      if (!rst && phase == 0) begin
         if (lsu_req_valid && !(ifu_req_valid && starve == STARVE_MAX)) e_lsu = 1'b1;
         else if (ifu_req_valid) e_ifu = 1'b1;
      end
      check("ifu_req_ready", 64'(ifu_req_ready), 64'(e_ifu));
      check("lsu_req_ready", 64'(lsu_req_ready), 64'(e_lsu));
      check("busy", 64'(busy), 64'(phase != 0));
      check("mem_req_valid", 64'(mem_req_valid), 64'(phase == 1));
      if (phase == 1) begin
         check("mem_req_addr", mem_req_addr, x_addr);
         check("mem_req_wen", 64'(mem_req_wen), 64'(x_wen));
         check("mem_req_wmask", 64'(mem_req_wmask), 64'(x_wmask));
         if (x_wen) check("mem_req_wdata", mem_req_wdata, x_wdata);
      end
      e_resp = (phase == 2) && mem_resp_valid;
      check("ifu_resp_valid", 64'(ifu_resp_valid), 64'(e_resp && !m_lsu));
      check("lsu_resp_valid", 64'(lsu_resp_valid), 64'(e_resp && m_lsu));

      if (rst) begin
         phase = 0; starve = 0; m_ifu_g = 0; m_lsu_g = 0; m_stall = 0;
         mem_out = 1'b0;
      end else begin
         case (phase)
            0: begin
               if (e_lsu) begin
                  phase = 1; m_lsu = 1'b1; m_lsu_g++;
                  x_addr = lsu_addr; x_wen = lsu_wen; x_wdata = lsu_wdata; x_wmask = lsu_wmask;
                  starve = ifu_req_valid ? starve + 1 : 0;
               end else if (e_ifu) begin
                  phase = 1; m_lsu = 1'b0; m_ifu_g++;
                  x_addr = ifu_addr; x_wen = 1'b0; x_wmask = '0;
                  starve = 0;
               end else if (!ifu_req_valid) begin
                  starve = 0;
               end
            end
            1: if (mem_req_ready) phase = 2; else m_stall++;
            default: if (mem_resp_valid) phase = 0; else m_stall++;
         endcase
         if (mem_req_valid && mem_req_ready) begin
            mem_out = 1'b1; mem_delay = $urandom_range(1, 3);
            mem_addr = mem_req_addr; mem_wen = mem_req_wen;
         end else if (mem_out && mem_resp_valid) begin
            mem_out = 1'b0;
         end
      end
      if (ifu_req_ready) ifu_pend = 1'b0;
      if (lsu_req_ready) lsu_pend = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      evaluate();
   endtask

   task automatic drain();
      int n;
      stim_en = 1'b0;
      p_rdy   = 100;
      n = 0;
      while ((ifu_pend || lsu_pend || phase != 0 || mem_out) && n < 400) begin
         cycle();
         n++;
      end
      if (ifu_pend || lsu_pend || phase != 0 || mem_out) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: transactions still open after %0d cycles, required none", n);
      end
   endtask

   task automatic check_idle_outputs();
      check("rst_ifu_req_ready", 64'(ifu_req_ready), 64'd0);
      check("rst_lsu_req_ready", 64'(lsu_req_ready), 64'd0);
      check("rst_ifu_resp_valid", 64'(ifu_resp_valid), 64'd0);
      check("rst_lsu_resp_valid", 64'(lsu_resp_valid), 64'd0);
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mem_req_addr", mem_req_addr, 64'd0);
      check("rst_mem_req_wen", 64'(mem_req_wen), 64'd0);
      check("rst_mem_req_wdata", mem_req_wdata, 64'd0);
      check("rst_mem_req_wmask", 64'(mem_req_wmask), 64'd0);
      check("rst_ifu_resp_data", ifu_resp_data, 64'd0);
      check("rst_lsu_resp_data", lsu_resp_data, 64'd0);
   endtask

   // Scoreboard monitor: pops the expected response whenever the DUT presents one.
   always @(negedge clk) begin
      lsu_exp_t e;
      if (ifu_resp_valid === 1'b1) begin
         if (ifu_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL ifu_resp_unexpected: got pulse, required none (t=%0t)", $time);
         end else check("ifu_resp_data", ifu_resp_data, ifu_q.pop_front());
      end
      if (lsu_resp_valid === 1'b1) begin
         if (lsu_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL lsu_resp_unexpected: got pulse, required none (t=%0t)", $time);
         end else begin
            e = lsu_q.pop_front();
            if (!e.st) check("lsu_load_data", lsu_resp_data, e.d);
         end
      end
   end

   int knobs[3][3] = '{'{50, 50, 60}, '{100, 100, 100}, '{30, 80, 35}};

   initial begin
      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_req_addr = '0;
      lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

      repeat (3) cycle();
      check_idle_outputs();
      rst_req = 1'b0;
      cycle();

      // Single fetch, single store, then both together (LSU first, IFU next)
      p_rdy = 100;
      issue_ifu(64'h8000_0000, 1'b1);
      drain();
      issue_lsu(64'h8000_1000, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F);
      drain();
      issue_ifu(64'h8000_0100, 1'b1);
      issue_lsu(64'h9000_0040, 1'b0, 64'd0, 8'hFF);
      drain();

      // Memory holds off acceptance while the IFU waits behind the LSU
      p_rdy = 0;
      issue_lsu(64'h9000_0080, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hA5);
      issue_ifu(64'h8000_0200, 1'b1);
      repeat (7) cycle();
      drain();

      for (int k = 0; k < 3; k++) begin
         p_ifu = knobs[k][0]; p_lsu = knobs[k][1]; p_rdy = knobs[k][2];
         stim_en = 1'b1;
         repeat (1200) cycle();
         drain();
      end

`ifdef ARB_PERF_CNT_EN
      check("perf_ifu_grant", perf_ifu_grant, 64'(m_ifu_g));
      check("perf_lsu_grant", perf_lsu_grant, 64'(m_lsu_g));
      check("perf_mem_stall", perf_mem_stall, 64'(m_stall));
`endif

      // Reset while waiting for a response abandons the fetch
      p_rdy = 100;
      issue_ifu(64'h8000_0040, 1'b0);
      for (int i = 0; i < 50 && phase != 2; i++) cycle();
      if (phase != 2) begin
         vectors++; miscompares++;
         $display("FAIL reset_setup_timeout: arbiter never reached response wait");
      end
      mem_delay = 8;
      rst_req = 1'b1;
      cycle();
      rst_req = 1'b0;
      cycle();
      check_idle_outputs();
      force_resp = 1'b1;
      cycle();
      force_resp = 1'b0;
      repeat (3) cycle();
`ifdef ARB_PERF_CNT_EN
      check("perf_ifu_after_rst", perf_ifu_grant, 64'(m_ifu_g));
`endif

      check("ifu_q_left", 64'(ifu_q.size()), 64'd0);
      check("lsu_q_left", 64'(lsu_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
